// File: rtl/proc_control_fsm_if.sv
// Bundles the instruction input, run request and all datapath control lines
// exchanged between the control FSM and the surrounding CPU datapath.
interface proc_control_fsm_if #(
    parameter int WORD = 16
);
    logic            Run;
    logic [WORD-1:0] din;
    logic [3:0]      select;
    logic [7:0]      Rin;
    logic            Ain;
    logic            Gin;
    logic [1:0]      alu_op;
    logic            Done;
    logic [8:0]      ir;

    modport master (
        output Run, din,
        input  select, Rin, Ain, Gin, alu_op, Done, ir
    );

    modport slave (
        input  Run, din,
        output select, Rin, Ain, Gin, alu_op, Done, ir
    );
endinterface

// File: rtl/proc_control_fsm.sv
// Instruction control unit: latches a 9-bit instruction in T0 and sequences
// the bus-mux select and register/A/G load enables through T1..T3.
module proc_control_fsm #(
    parameter int WORD = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    proc_control_fsm_if.slave    bus
);

    // One-hot encoding leaves spare codes, all of which fall back to T0.
    typedef enum logic [3:0] {
        T0 = 4'b0001,
        T1 = 4'b0010,
        T2 = 4'b0100,
        T3 = 4'b1000
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;

    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_DIN  = 4'd9;
    localparam logic [3:0] SEL_IDLE = 4'hF;

    function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
        reg_onehot = 8'b0000_0001 << idx;
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        is_alu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        case (op)
            OP_SUB:  alu_code = 2'b01;
            OP_AND:  alu_code = 2'b10;
            default: alu_code = 2'b00;
        endcase
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic [8:0] ir_r;

    logic [2:0] op_s;
    logic [2:0] rx_s;
    logic [2:0] ry_s;

    logic [3:0] select_s;
    logic [7:0] rin_s;
    logic       ain_s;
    logic       gin_s;
    logic [1:0] alu_op_s;
    logic       done_s;

    assign op_s = ir_r[8:6];
    assign rx_s = ir_r[5:3];
    assign ry_s = ir_r[2:0];

    // Timing state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= T0;
        end else begin
            state_r <= next_s;
        end
    end

    // Instruction register: loads only when a Run request is accepted in T0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ir_r <= 9'd0;
        end else if ((state_r == T0) && bus.Run) begin
            ir_r <= bus.din[8:0];
        end else begin
            ir_r <= ir_r;
        end
    end

    // Next-state and control decode; outputs stay idle while reset is held.
    always_comb begin
        next_s   = state_r;
        select_s = SEL_IDLE;
        rin_s    = 8'h00;
        ain_s    = 1'b0;
        gin_s    = 1'b0;
        alu_op_s = 2'b00;
        done_s   = 1'b0;
        if (!Resetn) begin
            next_s = T0;
        end else begin
            case (state_r)
                T0: begin
                    if (bus.Run) begin
                        next_s = T1;
                    end else begin
                        next_s = T0;
                    end
                end
                T1: begin
                    case (op_s)
                        OP_MV: begin
                            select_s = {1'b0, ry_s};
                            rin_s    = reg_onehot(rx_s);
                            done_s   = 1'b1;
                            next_s   = T0;
                        end
                        OP_MVI: begin
                            select_s = SEL_DIN;
                            rin_s    = reg_onehot(rx_s);
                            done_s   = 1'b1;
                            next_s   = T0;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            select_s = {1'b0, rx_s};
                            ain_s    = 1'b1;
                            next_s   = T2;
                        end
                        default: begin
                            done_s = 1'b1;
                            next_s = T0;
                        end
                    endcase
                end
                T2: begin
                    // Only ALU opcodes reach T2; anything else is abandoned quietly.
                    if (is_alu_op(op_s)) begin
                        select_s = {1'b0, ry_s};
                        gin_s    = 1'b1;
                        alu_op_s = alu_code(op_s);
                        next_s   = T3;
                    end else begin
                        next_s = T0;
                    end
                end
                T3: begin
                    if (is_alu_op(op_s)) begin
                        select_s = SEL_G;
                        rin_s    = reg_onehot(rx_s);
                        done_s   = 1'b1;
                    end else begin
                        done_s = 1'b0;
                    end
                    next_s = T0;
                end
                default: begin
                    next_s = T0;
                end
            endcase
        end
    end

    assign bus.select = select_s;
    assign bus.Rin    = rin_s;
    assign bus.Ain    = ain_s;
    assign bus.Gin    = gin_s;
    assign bus.alu_op = alu_op_s;
    assign bus.Done   = done_s;
    assign bus.ir     = ir_r;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench: each stimulus cycle queues the hand-computed control word
// for that cycle; a negedge monitor pops and compares against the DUT.
module tb_proc_control_fsm;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic [1:0] op;
        logic       done;
        logic [8:0] ir;
    } exp_t;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    int   step_no;
    exp_t exp_q[$];
    int   tag_q[$];

    proc_control_fsm_if #(.WORD(16)) pif ();

    proc_control_fsm #(.WORD(16)) dut (
        .Clock  (clk),
        .Resetn (resetn),
        .bus    (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic run, input logic [15:0] d,
                        input logic [3:0] sel, input logic [7:0] rin,
                        input logic ain, input logic gin, input logic [1:0] op,
                        input logic done, input logic [8:0] irv);
        exp_t e;
        resetn  = rst;
        pif.Run = run;
        pif.din = d;
        e = '{sel: sel, rin: rin, ain: ain, gin: gin, op: op, done: done, ir: irv};
        exp_q.push_back(e);
        tag_q.push_back(step_no);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rst, input logic run, input logic [15:0] d,
                        input logic [8:0] irv);
        step(rst, run, d, 4'hF, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, irv);
    endtask

    // Monitor: compare the DUT control word against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{sel: pif.select, rin: pif.Rin, ain: pif.Ain, gin: pif.Gin,
                  op: pif.alu_op, done: pif.Done, ir: pif.ir};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL step%0d: got sel=%h rin=%h ain=%b gin=%b op=%b done=%b ir=%h, want sel=%h rin=%h ain=%b gin=%b op=%b done=%b ir=%h",
                         t, a.sel, a.rin, a.ain, a.gin, a.op, a.done, a.ir,
                         e.sel, e.rin, e.ain, e.gin, e.op, e.done, e.ir);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        step_no = 0;
        resetn  = 1'b0;
        pif.Run = 1'b0;
        pif.din = 16'h0000;
        @(posedge clk);
        #1;
        // Reset held, then released with Run low.
        idle(1'b0, 1'b1, 16'h01FF, 9'h000);
        idle(1'b0, 1'b0, 16'h0000, 9'h000);
        idle(1'b1, 1'b0, 16'h0000, 9'h000);

        // mv R3,R5 with junk in din[15:9].
        idle(1'b1, 1'b1, 16'hFE1D, 9'h000);
        step(1'b1, 1'b0, 16'h0000, 4'd5, 8'h08, 1'b0, 1'b0, 2'b00, 1'b1, 9'h01D);
        idle(1'b1, 1'b0, 16'h0000, 9'h01D);

        // mvi R2 with immediate 00A5.
        idle(1'b1, 1'b1, 16'h0050, 9'h01D);
        step(1'b1, 1'b0, 16'h00A5, 4'd9, 8'h04, 1'b0, 1'b0, 2'b00, 1'b1, 9'h050);

        // sub R1,R6.
        idle(1'b1, 1'b1, 16'h00CE, 9'h050);
        step(1'b1, 1'b0, 16'h0000, 4'd1, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 9'h0CE);
        step(1'b1, 1'b0, 16'h0000, 4'd6, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 9'h0CE);
        step(1'b1, 1'b0, 16'h0000, 4'd8, 8'h02, 1'b0, 1'b0, 2'b00, 1'b1, 9'h0CE);

        // Back-to-back with Run held: mv R1,R2 / add R4,R7 / mvi R6.
        idle(1'b1, 1'b1, 16'h000A, 9'h0CE);
        step(1'b1, 1'b1, 16'h00A7, 4'd2, 8'h02, 1'b0, 1'b0, 2'b00, 1'b1, 9'h00A);
        idle(1'b1, 1'b1, 16'h00A7, 9'h00A);
        step(1'b1, 1'b1, 16'h0070, 4'd4, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 9'h0A7);
        step(1'b1, 1'b1, 16'h0070, 4'd7, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 9'h0A7);
        step(1'b1, 1'b1, 16'h0070, 4'd8, 8'h10, 1'b0, 1'b0, 2'b00, 1'b1, 9'h0A7);
        idle(1'b1, 1'b1, 16'h0070, 9'h0A7);
        step(1'b1, 1'b1, 16'h1234, 4'd9, 8'h40, 1'b0, 1'b0, 2'b00, 1'b1, 9'h070);
        idle(1'b1, 1'b0, 16'h1234, 9'h070);

        // and R0,R3.
        idle(1'b1, 1'b1, 16'h0103, 9'h070);
        step(1'b1, 1'b0, 16'h0000, 4'd0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 9'h103);
        step(1'b1, 1'b0, 16'h0000, 4'd3, 8'h00, 1'b0, 1'b1, 2'b10, 1'b0, 9'h103);
        step(1'b1, 1'b0, 16'h0000, 4'd8, 8'h01, 1'b0, 1'b0, 2'b00, 1'b1, 9'h103);

        // mv R3,R3 (X==Y).
        idle(1'b1, 1'b1, 16'h001B, 9'h103);
        step(1'b1, 1'b0, 16'h0000, 4'd3, 8'h08, 1'b0, 1'b0, 2'b00, 1'b1, 9'h01B);

        // add R2,R2 aborted by reset during T2.
        idle(1'b1, 1'b1, 16'h0092, 9'h01B);
        step(1'b1, 1'b0, 16'h0000, 4'd2, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 9'h092);
        idle(1'b0, 1'b0, 16'h0000, 9'h000);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0, 16'h0092, 9'h000);
        end

        // NOP opcode 110, then Run low for 10 cycles with changing din.
        idle(1'b1, 1'b1, 16'h0180, 9'h000);
        step(1'b1, 1'b0, 16'h0000, 4'hF, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 9'h180);
        for (int i = 0; i < 10; i++) begin
            idle(1'b1, 1'b0, 16'(i * 16'h0137), 9'h180);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
